// File: rtl/rptr_empty_lvl_if.sv
// Read-side FIFO control bundle: pop request and synced write pointer in,
// address, Gray pointer, empty/level/almost-empty and underflow flags out.
interface rptr_empty_lvl_if #(
  parameter int ADDRSIZE = 9
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                ralmost_empty;
  logic                rerr;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty,
    input  rlevel, ralmost_empty, rerr
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty,
    output rlevel, ralmost_empty, rerr
  );
endinterface

// File: rtl/rptr_empty_lvl.sv
// Async FIFO read pointer / empty / fill-level controller (rclk domain).
// Ports: rclk, rrst (sync, active-high), bus (slave: rinc, rq2_wptr in;
//   raddr, rptr, rempty, rlevel, ralmost_empty, rerr out).
// Macro RPTR_UNDERFLOW_DET_EN compiles in the sticky rerr register.
module rptr_empty_lvl #(
  parameter int ADDRSIZE  = 9,
  parameter int AE_THRESH = 4
) (
  input logic            rclk,
  input logic            rrst,
  rptr_empty_lvl_if.slave bus
);

  localparam logic [ADDRSIZE:0] AE_LIM =
    (ADDRSIZE+1)'(AE_THRESH);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rgray;
  logic [ADDRSIZE:0] rlvl;
  logic              rempty_q;
  logic              rae_q;

  logic              pop;
  logic [ADDRSIZE:0] rbin_nx;
  logic [ADDRSIZE:0] rgray_nx;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rlvl_nx;
  logic              rempty_nx;
  logic              rae_nx;

  // Gating by the registered empty makes a held rinc on empty harmless.
  assign pop = bus.rinc & ~rempty_q;

  always_comb begin
    rbin_nx  = rbin + {{ADDRSIZE{1'b0}}, pop};
    rgray_nx = (rbin_nx >> 1) ^ rbin_nx;
    // Gray to binary: XOR prefix from the MSB down.
    wbin           = '0;
    wbin[ADDRSIZE] = bus.rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ bus.rq2_wptr[i];
    end
    // Modulo difference; 2^ADDRSIZE encodes a full FIFO.
    rlvl_nx   = wbin - rbin_nx;
    rempty_nx = (rgray_nx == bus.rq2_wptr);
    rae_nx    = (rlvl_nx <= AE_LIM);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rgray    <= '0;
      rlvl     <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
    end else begin
      rbin     <= rbin_nx;
      rgray    <= rgray_nx;
      rlvl     <= rlvl_nx;
      rempty_q <= rempty_nx;
      rae_q    <= rae_nx;
    end
  end

`ifdef RPTR_UNDERFLOW_DET_EN
  logic err_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      err_q <= 1'b0;
    end else if (bus.rinc & rempty_q) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rerr = err_q;
`else
  assign bus.rerr = 1'b0;
`endif

  assign bus.raddr         = rbin[ADDRSIZE-1:0];
  assign bus.rptr          = rgray;
  assign bus.rempty        = rempty_q;
  assign bus.rlevel        = rlvl;
  assign bus.ralmost_empty = rae_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Scoreboard bench for rptr_empty_lvl (ADDRSIZE=3, AE_THRESH=4).
// Directed steps push expected outputs; a negedge monitor compares.
module tb_rptr_empty_lvl;

`ifdef RPTR_UNDERFLOW_DET_EN
  localparam logic UD = 1'b1;
`else
  localparam logic UD = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic [3:0] rlevel;
    logic       rae;
    logic       rerr;
  } exp_t;

  logic clk;
  logic rrst;
  int   checks;
  int   errors;
  int   stepn;
  exp_t exp_q[$];

  rptr_empty_lvl_if #(.ADDRSIZE(3)) bus();

  rptr_empty_lvl #(
    .ADDRSIZE (3),
    .AE_THRESH(4)
  ) dut (
    .rclk(clk),
    .rrst(rrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       rst,
    input logic       inc,
    input logic [3:0] w,
    input logic [2:0] ea,
    input logic [3:0] ep,
    input logic       ee,
    input logic [3:0] el,
    input logic       eae,
    input logic       eer
  );
    exp_t e;
    @(negedge clk);
    rrst         = rst;
    bus.rinc     = inc;
    bus.rq2_wptr = w;
    @(posedge clk);
    #1;
    e.id     = stepn;
    e.raddr  = ea;
    e.rptr   = ep;
    e.rempty = ee;
    e.rlevel = el;
    e.rae    = eae;
    e.rerr   = eer;
    exp_q.push_back(e);
    stepn++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.raddr !== e.raddr || bus.rptr !== e.rptr ||
          bus.rempty !== e.rempty || bus.rlevel !== e.rlevel ||
          bus.ralmost_empty !== e.rae || bus.rerr !== e.rerr) begin
        errors++;
        $display("FAIL step%0d got a=%0d p=%b e=%b l=%0d ae=%b er=%b exp a=%0d p=%b e=%b l=%0d ae=%b er=%b",
          e.id, bus.raddr, bus.rptr, bus.rempty, bus.rlevel,
          bus.ralmost_empty, bus.rerr, e.raddr, e.rptr,
          e.rempty, e.rlevel, e.rae, e.rerr);
      end
    end
  end

  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    stepn        = 0;
    rrst         = 1'b1;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = 4'b0000;

    // reset held with rinc=1
    step(1, 1, 4'b0000, 0, 4'b0000, 1, 0, 1, 0);
    step(1, 1, 4'b0000, 0, 4'b0000, 1, 0, 1, 0);
    // fill 3 then drain
    step(0, 0, 4'b0010, 0, 4'b0000, 0, 3, 1, 0);
    step(0, 1, 4'b0010, 1, 4'b0001, 0, 2, 1, 0);
    step(0, 1, 4'b0010, 2, 4'b0011, 0, 1, 1, 0);
    step(0, 1, 4'b0010, 3, 4'b0010, 1, 0, 1, 0);
    // underflow: pointers hold, rerr sticky
    step(0, 1, 4'b0010, 3, 4'b0010, 1, 0, 1, UD);
    step(0, 0, 4'b0010, 3, 4'b0010, 1, 0, 1, UD);
    // reset clears rerr
    step(1, 0, 4'b0000, 0, 4'b0000, 1, 0, 1, 0);
    // full (bin 8) then 8 pops with wrap
    step(0, 0, 4'b1100, 0, 4'b0000, 0, 8, 0, 0);
    step(0, 1, 4'b1100, 1, 4'b0001, 0, 7, 0, 0);
    step(0, 1, 4'b1100, 2, 4'b0011, 0, 6, 0, 0);
    step(0, 1, 4'b1100, 3, 4'b0010, 0, 5, 0, 0);
    step(0, 1, 4'b1100, 4, 4'b0110, 0, 4, 1, 0);
    step(0, 1, 4'b1100, 5, 4'b0111, 0, 3, 1, 0);
    step(0, 1, 4'b1100, 6, 4'b0101, 0, 2, 1, 0);
    step(0, 1, 4'b1100, 7, 4'b0100, 0, 1, 1, 0);
    step(0, 1, 4'b1100, 0, 4'b1100, 1, 0, 1, 0);
    // simultaneous pop and wptr change
    step(1, 0, 4'b0000, 0, 4'b0000, 1, 0, 1, 0);
    step(0, 0, 4'b0010, 0, 4'b0000, 0, 3, 1, 0);
    step(0, 1, 4'b0010, 1, 4'b0001, 0, 2, 1, 0);
    step(0, 1, 4'b0010, 2, 4'b0011, 0, 1, 1, 0);
    step(0, 1, 4'b0111, 3, 4'b0010, 0, 2, 1, 0);
    // mid-operation reset beats a pending pop
    step(0, 0, 4'b1100, 3, 4'b0010, 0, 5, 0, 0);
    step(1, 1, 4'b1100, 0, 4'b0000, 1, 0, 1, 0);
    step(0, 0, 4'b1100, 0, 4'b0000, 0, 8, 0, 0);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
